lab4_diff_ram: RTL
==================

Name: lab4_diff_ram

Overview:
- 16-entry x 5-bit RAM that sits directly downstream of the lab4ROM lookup.
- Drives the ROM address. On a write it stores the absolute difference between the ROM word and the user input. Reads come back registered.
- A scan engine streams all 16 entries out, one per cycle, to the display/checker stage.

Parameters:
- ADDR_W, 4, address width (ROM and RAM share the same address space)
- DATA_W, 5, word width (matches the ROM output)
- DEPTH, 16, number of entries, equal to 2**ADDR_W

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- RST  input  1  synchronous, active-high reset
- mode  input  1  0 = write, 1 = read
- ramAddr  input  ADDR_W  RAM/ROM address for the current operation
- ramInput  input  DATA_W  user operand for writes
- romAddr  output  ADDR_W  address to lab4ROM; combinational, equal to ramAddr
- romData  input  DATA_W  lab4ROM output for romAddr; combinational, same cycle
- ramOutput  output  DATA_W  registered read data
- start  input  1  single-cycle pulse that requests a full-memory scan
- busy  output  1  high while a scan is in progress
- scanValid  output  1  high on cycles that carry a scan word
- scanAddr  output  ADDR_W  index of the current scan word
- scanData  output  DATA_W  contents of mem[scanAddr]

Behaviour:
- Reset (RST=1 at a clock edge):
  - All 16 entries are cleared to 0 in that one cycle.
  - ramOutput, busy, scanValid, scanAddr and scanData all go to 0.
  - The FSM goes to IDLE.
  - RST has priority over every other input, including in the middle of a scan (the scan is aborted with no further scanValid).
- Write (mode=0, busy=0):
  - At the edge, mem[ramAddr] <= |romData - ramInput|, computed unsigned at DATA_W bits: the larger operand minus the smaller, so there is no wrap.
  - ramOutput holds its previous value.
- Read (mode=1):
  - At the edge, ramOutput <= mem[ramAddr]: one-cycle latency, and the value holds until the next read.
  - Reads are served in both IDLE and SCAN.
  - A read of an address written in the previous cycle returns the new value.
- Writes while busy=1 are dropped, with no memory change. This keeps the scan snapshot consistent.
- FSM with two states, IDLE and SCAN:
  - IDLE -> SCAN on start=1: busy<=1 and the pointer is set to 0.
  - In SCAN, each cycle registers scanAddr<=ptr, scanData<=mem[ptr] and scanValid<=1, then increments ptr.
  - After ptr=DEPTH-1 is emitted, the FSM returns to IDLE: busy<=0 on the same edge as the last word, and scanValid drops on the following edge.
  - The first scanValid appears one cycle after the start edge.
  - Exactly DEPTH consecutive valid cycles are produced, addresses 0..15 in order, with no gaps.
  - start while busy=1 is ignored; it is not queued.
  - start together with a write in the same cycle: the write is committed first, then the scan begins. The scan sees the new value.
- scanValid=0 outside a scan. scanAddr and scanData hold their last values when scanValid=0.
- romAddr is purely combinational from ramAddr and has no registered path.

Test Plan:
- Reset: assert RST for 1 cycle, then read addresses 0..15 -> ramOutput=0 for each, one cycle after each read; busy=0 and scanValid=0.
- Absolute-difference write, with ROM[2]=5'b00110:
  - ramAddr=2, ramInput=5'b00001, mode=0, then read addr 2 -> ramOutput=5'b00101.
  - Rewrite with ramInput=5'b01000, then read -> 5'b00010.
- Zero and edge cases, with ROM[0]=5'b00000:
  - Write ramInput=5'b11111 to addr 0 -> read returns 5'b11111.
  - Write ramInput equal to the ROM word -> read returns 0.
- Scan: preload addr 2=5, addr 15=7, then pulse start ->
  - exactly 16 scanValid cycles, starting 1 cycle after start, with scanAddr 0..15 in order;
  - scanData is 5 at addr 2, 7 at addr 15, and 0 elsewhere;
  - busy is high for 16 cycles.
- Scan interference: mid-scan, issue a write to addr 3, a second start, and a read of addr 2 ->
  - addr 3 is unchanged afterwards and no second scan runs;
  - the read returns 5 one cycle later.
- Reset mid-scan: assert RST at scan word 6 -> next edge has scanValid=0 and busy=0, and all entries read back 0.

Source files
------------

// File: rtl/lab4_diff_ram.sv
// 16x5 difference RAM behind the lab4ROM lookup: writes store |romData - ramInput|,
// reads are registered, and a scan engine streams every entry out once per start pulse.
module lab4_diff_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 5,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mode,
  input  logic [ADDR_W-1:0] ramAddr,
  input  logic [DATA_W-1:0] ramInput,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [DATA_W-1:0] romData,
  output logic [DATA_W-1:0] ramOutput,
  input  logic              start,
  output logic              busy,
  output logic              scanValid,
  output logic [ADDR_W-1:0] scanAddr,
  output logic [DATA_W-1:0] scanData
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;

  // Larger operand minus the smaller, so the stored value never wraps.
  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign romAddr = ramAddr;
  // Writes are frozen during a scan so the streamed image is a consistent snapshot.
  assign wr_en   = !mode && !busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[ramAddr] <= abs_diff(romData, ramInput);
    end
  end

  // Registered read port and scan sequencer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      busy      <= 1'b0;
      scanValid <= 1'b0;
      scanAddr  <= '0;
      scanData  <= '0;
      ramOutput <= '0;
    end else begin
      if (mode) ramOutput <= mem[ramAddr];
      case (state)
        IDLE: begin
          scanValid <= 1'b0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
            ptr   <= '0;
          end
        end
        SCAN: begin
          scanValid <= 1'b1;
          scanAddr  <= ptr;
          scanData  <= mem[ptr];
          ptr       <= ptr + ADDR_W'(1);
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
